scoreboarded_register_file: RTL and testbench
=============================================

// Module: scoreboarded_register_file
// PURPOSE
//   Parametrised successor to the CPU's 2-read/1-write register file.
//   - Synchronous reset.
//   - Configurable width and depth.
//   - One register is a read-only PC alias that reads pc + PC_OFFSET.
//   - Per-register pending (scoreboard) bits, so the decode stage can stall on RAW/WAW hazards.
//   - Sits between decode (read ports + issue) and writeback (write port).
// PARAMETERS
//   DATA_W     32  register / data width in bits
//   ADDR_W     4   register address width
//   NUM_REGS   16  implemented registers, <= 2**ADDR_W; addresses >= NUM_REGS read 0
//   PC_REG     15  address aliased to pc + PC_OFFSET; never written, never pending
//   PC_OFFSET  8   constant added to pc on a PC_REG read
// PORTS
//   clk          in   1         single clock, all state updates on rising edge
//   rst          in   1         synchronous, active-high reset
//   pc           in   DATA_W    current PC, used for PC_REG reads
//   readAddr1    in   ADDR_W    read port 1 address (also issuing instr. source 1)
//   readAddr2    in   ADDR_W    read port 2 address (also issuing instr. source 2)
//   readData1    out  DATA_W    combinational read data, port 1
//   readData2    out  DATA_W    combinational read data, port 2
//   writeEnable  in   1         writeback strobe
//   writeAddr    in   ADDR_W    writeback destination
//   writeData    in   DATA_W    writeback data
//   issueValid   in   1         decode presents an instruction this cycle
//   issueUse1    in   1         instruction reads readAddr1
//   issueUse2    in   1         instruction reads readAddr2
//   issueHasDest in   1         instruction will write issueDest
//   issueDest    in   ADDR_W    destination register of issuing instruction
//   stall        out  1         instruction NOT accepted this cycle; decode must hold
//   pendingCount out  ADDR_W+1  number of registers currently pending
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all registers <= 0 and all pending bits <= 0.
//     - While rst=1: stall=0; writes and issues are ignored.
//     - Reset mid-operation discards all outstanding pending state.
//   - Reads (combinational, 0-cycle latency):
//     - addr==PC_REG -> pc + PC_OFFSET, truncated to DATA_W (wraps).
//     - addr>=NUM_REGS -> 0.
//     - otherwise -> registers[addr].
//   - Write (posedge): if writeEnable && writeAddr<NUM_REGS && writeAddr!=PC_REG, then registers[writeAddr] <= writeData.
//     - Writes to PC_REG or out-of-range addresses are dropped silently.
//   - busy(a) = pending[a], with the same-cycle clearing given under CONFIGURATION.
//   - stall = issueValid & !rst & ((issueUse1 & busy(readAddr1)) | (issueUse2 & busy(readAddr2)) | (issueHasDest & busy(issueDest))).
//   - Accepted issue = issueValid & !stall.
//   - Pending update (posedge):
//     - An accepted write to a register clears its pending bit.
//     - An accepted issue with issueHasDest sets pending[issueDest].
//     - Set wins over clear on the same register in the same cycle (the new producer owns it).
//     - issueDest==PC_REG or issueDest>=NUM_REGS: no pending bit is set; the issue is still accepted.
//     - A write to a non-pending register is legal: data is written, pending stays 0.
//   - pendingCount: registered population count of the pending bits; updates 1 cycle after the bit change; 0 after reset.
// CONFIGURATION
//   WRITE_BYPASS_EN defined:
//     - readDataN returns writeData when writeEnable && writeAddr==readAddrN (writable register).
//     - busy(a) is 0 when the same cycle writes a, so a dependent instruction issues in the writeback cycle.
//   WRITE_BYPASS_EN undefined:
//     - Reads return the pre-write value.
//     - busy(a) = pending[a], so dependants stall one extra cycle after writeback.
// TESTING
//   1. rst=1 for 2 cycles, then read r0..r14 -> all 0; pendingCount=0; stall=0.
//   2. pc=0x100, readAddr1=15 -> readData1=0x108; pc=0xFFFFFFFC -> 0x4 (wrap); write r15=0xDEAD -> r15 still reads pc+8.
//   3. Issue dest r3 -> pendingCount=1.
//      - Next cycle: issue with issueUse1 and readAddr1=3 -> stall=1.
//      - Write r3=0x55: with bypass, same cycle stall=0 and readData1=0x55; without bypass, stall=0 one cycle later.
//   4. Same cycle: write r5 and issue with dest r5 (r5 pending, bypass on) -> accepted; pending[5] remains 1; pendingCount unchanged.
//   5. Issue dest r2, then issue dest r2 again -> second stalls (WAW); issue with dest 15 -> accepted, pendingCount unchanged.
//   6. Pend r1, r2, r4, then assert rst mid-sequence -> pendingCount=0 next cycle; registers read 0; writes during rst have no effect.

Source files
------------

// File: rtl/scoreboarded_register_file_if.sv
// Decode/writeback bus of the scoreboarded register file.
// The master side is the pipeline (decode + writeback); the slave side is the register file.
interface scoreboarded_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] readAddr1;
    logic [ADDR_W-1:0] readAddr2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              writeEnable;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic              issueValid;
    logic              issueUse1;
    logic              issueUse2;
    logic              issueHasDest;
    logic [ADDR_W-1:0] issueDest;
    logic              stall;
    logic [ADDR_W:0]   pendingCount;

    modport master (
        output pc, readAddr1, readAddr2, writeEnable, writeAddr, writeData,
        output issueValid, issueUse1, issueUse2, issueHasDest, issueDest,
        input  readData1, readData2, stall, pendingCount
    );

    modport slave (
        input  pc, readAddr1, readAddr2, writeEnable, writeAddr, writeData,
        input  issueValid, issueUse1, issueUse2, issueHasDest, issueDest,
        output readData1, readData2, stall, pendingCount
    );
endinterface

// File: rtl/scoreboarded_register_file.sv
// 2-read/1-write register file with a read-only PC alias and per-register
// pending bits used by decode to stall on RAW/WAW hazards.
// Optional feature: define WRITE_BYPASS_EN to forward same-cycle writeback data
// to the read ports and let dependants issue in the writeback cycle.
module scoreboarded_register_file #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_REGS  = 16,
    parameter int PC_REG    = 15,
    parameter int PC_OFFSET = 8
) (
    input logic clk,
    input logic rst,
    scoreboarded_register_file_if.slave bus
);
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);
    localparam logic [DATA_W-1:0] PC_OFF  = DATA_W'(PC_OFFSET);
    localparam logic [ADDR_W:0]   NREGS   = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [ADDR_W:0]     pend_count_q;

    logic                wr_ok;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] busy_clr;
    logic [NUM_REGS-1:0] dest_set;
    logic                stall_c;
    logic                accept;

    // Writable = implemented and not the PC alias.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS) && (a != PC_ADDR);
    endfunction

    // Pending bit of an address, masked by a same-cycle clear; unimplemented
    // addresses and the PC alias are never busy.
    function automatic logic busy(input logic [ADDR_W-1:0] a,
                                  input logic [NUM_REGS-1:0] pend,
                                  input logic [NUM_REGS-1:0] clr);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (a == ADDR_W'(i)) b = pend[i] & ~clr[i];
        return b;
    endfunction

    // Combinational read: PC alias, then register array (optionally bypassed), else 0.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] pc,
                                                    input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] d;
        d = '0;
        if (a == PC_ADDR) begin
            d = pc + PC_OFF;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (a == ADDR_W'(i)) d = busy_clr[i] ? wdata : regs[i];
        end
        return d;
    endfunction

    // Decode writeback and issue into one-hot set/clear vectors and the stall decision.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' with a default for every
        // variable first, so no path leaves a value held and no latch is inferred.
        wr_ok    = bus.writeEnable && writable(bus.writeAddr);
        wr_hit   = '0;
        dest_set = '0;
        for (int i = 0; i < NUM_REGS; i++)
            wr_hit[i] = wr_ok && (bus.writeAddr == ADDR_W'(i));
`ifdef WRITE_BYPASS_EN
        busy_clr = wr_hit;
`else
        busy_clr = '0;
`endif
        stall_c = bus.issueValid && !rst &&
                  ((bus.issueUse1    && busy(bus.readAddr1, pending, busy_clr)) ||
                   (bus.issueUse2    && busy(bus.readAddr2, pending, busy_clr)) ||
                   (bus.issueHasDest && busy(bus.issueDest, pending, busy_clr)));
        accept  = bus.issueValid && !stall_c && !rst;
        for (int i = 0; i < NUM_REGS; i++)
            dest_set[i] = accept && bus.issueHasDest && writable(bus.issueDest) &&
                          (bus.issueDest == ADDR_W'(i));
    end

    // Drive the combinational outputs.
    always_comb begin
        bus.readData1    = read_port(bus.readAddr1, bus.pc, bus.writeData);
        bus.readData2    = read_port(bus.readAddr2, bus.pc, bus.writeData);
        bus.stall        = stall_c;
        bus.pendingCount = pend_count_q;
    end

    // Register array: cleared on reset, updated by accepted writebacks.
    always_ff @(posedge clk) begin
        // NOTE: the array is built from flops rather than RAM because reset must
        // clear every register; sequential state uses non-blocking '<='.
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_hit[i]) regs[i] <= bus.writeData;
        end
    end

    // Scoreboard: writeback clears, accepted issue sets; set wins on the same register.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~wr_hit) | dest_set;
    end

    // Registered population count of the pending bits (lags the bits by one cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_count_q <= '0;
        end else begin
            logic [ADDR_W:0] cnt;
            cnt = '0;
            for (int i = 0; i < NUM_REGS; i++) cnt = cnt + (ADDR_W+1)'(pending[i]);
            pend_count_q <= cnt;
        end
    end
endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Directed bench for scoreboarded_register_file (default and WRITE_BYPASS_EN builds).
module tb_scoreboarded_register_file;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    scoreboarded_register_file_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    scoreboarded_register_file #(
        .DATA_W(32), .ADDR_W(4), .NUM_REGS(16), .PC_REG(15), .PC_OFFSET(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.writeEnable  = 1'b0;
        bus.writeAddr    = '0;
        bus.writeData    = '0;
        bus.issueValid   = 1'b0;
        bus.issueUse1    = 1'b0;
        bus.issueUse2    = 1'b0;
        bus.issueHasDest = 1'b0;
        bus.issueDest    = '0;
    endtask

    task automatic issue(input logic [3:0] dest, input logic has_dest,
                         input logic [3:0] src1, input logic use1);
        bus.issueValid   = 1'b1;
        bus.issueHasDest = has_dest;
        bus.issueDest    = dest;
        bus.readAddr1    = src1;
        bus.issueUse1    = use1;
        bus.issueUse2    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.pc = 32'h0;
        bus.readAddr1 = '0;
        bus.readAddr2 = '0;
        tick();
        tick();
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) begin
            bus.readAddr1 = 4'(i);
            #1;
            checks++; if (bus.readData1 !== 32'h0) begin errors++; $display("FAIL reset_r%0d: got %h want 0", i, bus.readData1); end
        end
        checks++; if (bus.pendingCount !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.pendingCount); end
    endtask

    task automatic test_pc_alias();
        bus.pc = 32'h100;
        bus.readAddr1 = 4'd15;
        #1;
        checks++; if (bus.readData1 !== 32'h108) begin errors++; $display("FAIL pc_alias: got %h want 108", bus.readData1); end
        bus.pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (bus.readData1 !== 32'h4) begin errors++; $display("FAIL pc_wrap: got %h want 4", bus.readData1); end
        bus.writeEnable = 1'b1; bus.writeAddr = 4'd15; bus.writeData = 32'hDEAD;
        tick();
        bus.writeAddr = 4'd7; bus.writeData = 32'h1234;
        tick();
        idle();
        bus.readAddr2 = 4'd15;
        bus.readAddr1 = 4'd7;
        #1;
        checks++; if (bus.readData2 !== 32'h4) begin errors++; $display("FAIL pc_write_dropped: got %h want 4", bus.readData2); end
        checks++; if (bus.readData1 !== 32'h1234) begin errors++; $display("FAIL write_r7: got %h want 1234", bus.readData1); end
    endtask

    task automatic test_raw();
        issue(4'd3, 1'b1, 4'd0, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue: stall got %b want 0", bus.stall); end
        tick();
        issue(4'd0, 1'b0, 4'd3, 1'b1);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", bus.stall); end
        tick();
        checks++; if (bus.pendingCount !== 5'd1) begin errors++; $display("FAIL raw_count: got %0d want 1", bus.pendingCount); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_hold: got %b want 1", bus.stall); end
        bus.writeEnable = 1'b1; bus.writeAddr = 4'd3; bus.writeData = 32'h55;
        #1;
`ifdef WRITE_BYPASS_EN
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_bypass_stall: got %b want 0", bus.stall); end
        checks++; if (bus.readData1 !== 32'h55) begin errors++; $display("FAIL raw_bypass_data: got %h want 55", bus.readData1); end
        tick();
        idle();
`else
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_wb_stall: got %b want 1", bus.stall); end
        checks++; if (bus.readData1 !== 32'h0) begin errors++; $display("FAIL raw_prewrite_data: got %h want 0", bus.readData1); end
        tick();
        bus.writeEnable = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_late_stall: got %b want 0", bus.stall); end
        checks++; if (bus.readData1 !== 32'h55) begin errors++; $display("FAIL raw_late_data: got %h want 55", bus.readData1); end
        tick();
        idle();
`endif
        tick();
        checks++; if (bus.pendingCount !== 5'd0) begin errors++; $display("FAIL raw_count_clear: got %0d want 0", bus.pendingCount); end
    endtask

    task automatic test_same_cycle_set_clear();
        issue(4'd5, 1'b1, 4'd0, 1'b0);
        tick();
        idle();
        tick();
        checks++; if (bus.pendingCount !== 5'd1) begin errors++; $display("FAIL sc_count_before: got %0d want 1", bus.pendingCount); end
        issue(4'd5, 1'b1, 4'd0, 1'b0);
        bus.writeEnable = 1'b1; bus.writeAddr = 4'd5; bus.writeData = 32'h77;
        #1;
`ifdef WRITE_BYPASS_EN
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sc_accept: stall got %b want 0", bus.stall); end
        tick();
`else
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sc_waw_stall: got %b want 1", bus.stall); end
        tick();
        bus.writeEnable = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sc_late_accept: stall got %b want 0", bus.stall); end
        tick();
`endif
        idle();
        tick();
        tick();
        checks++; if (bus.pendingCount !== 5'd1) begin errors++; $display("FAIL sc_count_after: got %0d want 1", bus.pendingCount); end
        issue(4'd0, 1'b0, 4'd5, 1'b1);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sc_still_pending: stall got %b want 1", bus.stall); end
        checks++; if (bus.readData1 !== 32'h77) begin errors++; $display("FAIL sc_data: got %h want 77", bus.readData1); end
        idle();
        bus.writeEnable = 1'b1; bus.writeAddr = 4'd5; bus.writeData = 32'h78;
        tick();
        idle();
        tick();
        checks++; if (bus.pendingCount !== 5'd0) begin errors++; $display("FAIL sc_count_clear: got %0d want 0", bus.pendingCount); end
    endtask

    task automatic test_waw_and_pc_dest();
        issue(4'd2, 1'b1, 4'd0, 1'b0);
        tick();
        issue(4'd2, 1'b1, 4'd0, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", bus.stall); end
        issue(4'd15, 1'b1, 4'd0, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL pc_dest_accept: stall got %b want 0", bus.stall); end
        tick();
        idle();
        tick();
        checks++; if (bus.pendingCount !== 5'd1) begin errors++; $display("FAIL pc_dest_count: got %0d want 1", bus.pendingCount); end
    endtask

    task automatic test_reset_mid_operation();
        issue(4'd1, 1'b1, 4'd0, 1'b0);
        tick();
        issue(4'd4, 1'b1, 4'd0, 1'b0);
        tick();
        idle();
        tick();
        checks++; if (bus.pendingCount !== 5'd3) begin errors++; $display("FAIL mid_count: got %0d want 3", bus.pendingCount); end
        rst = 1'b1;
        bus.writeEnable = 1'b1; bus.writeAddr = 4'd6; bus.writeData = 32'hABCD;
        issue(4'd7, 1'b1, 4'd1, 1'b1);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++; if (bus.pendingCount !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.pendingCount); end
        bus.readAddr1 = 4'd6; bus.readAddr2 = 4'd3;
        #1;
        checks++; if (bus.readData1 !== 32'h0) begin errors++; $display("FAIL rst_write_ignored: got %h want 0", bus.readData1); end
        checks++; if (bus.readData2 !== 32'h0) begin errors++; $display("FAIL rst_r3_cleared: got %h want 0", bus.readData2); end
        issue(4'd0, 1'b0, 4'd1, 1'b1);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_pending_cleared: stall got %b want 0", bus.stall); end
        tick();
        idle();
        tick();
        checks++; if (bus.pendingCount !== 5'd0) begin errors++; $display("FAIL rst_issue_ignored: got %0d want 0", bus.pendingCount); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_pc_alias();
        test_raw();
        test_same_cycle_set_clear();
        test_waw_and_pc_dest();
        test_reset_mid_operation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
